// File: rtl/uart_tx_sequencer.sv
// Byte FIFO feeding the UART control register: each byte is launched as data + tnsm
// through the masked write port, and the next launch waits for tnsm and busy to clear.
module uart_tx_sequencer #(
    parameter int DEPTH      = 16,
    parameter int ACTIVE_BIT = 0,
    parameter int TNSM_BIT   = 10,
    parameter int DATA_LSB   = 11,
    parameter int TBUSY_BIT  = 11
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       wr_valid,
    input  logic [7:0]                 wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    input  logic                       cfg_we,
    input  logic [18:0]                cfg_wdata,
    input  logic [18:0]                cfg_wmask,
    output logic                       ctl_reg_we,
    output logic [18:0]                ctl_reg_wdata,
    output logic [18:0]                ctl_reg_wmask,
    input  logic [18:0]                ctl_reg_rdata,
    input  logic [11:0]                st_reg_rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       tx_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [18:0] TNSM_MASK  = 19'h1 << TNSM_BIT;
    localparam logic [18:0] DATA_MASK  = 19'hFF << DATA_LSB;
    localparam logic [18:0] OWNED_MASK = TNSM_MASK | DATA_MASK;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_HOLD, S_WAIT_CLR} state_t;

    state_t             state_q;
    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               push;
    logic               pop;
    logic               tx_clear;
    logic               unused_bits;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign wr_ready = !full;

    assign push     = wr_valid && !full && !flush;
    assign pop      = (state_q == S_LAUNCH) && !cfg_we;
    assign tx_clear = !ctl_reg_rdata[TNSM_BIT] && !st_reg_rdata[TBUSY_BIT];
    assign tx_done  = (state_q == S_WAIT_CLR) && tx_clear;

    assign unused_bits = ^{ctl_reg_rdata, st_reg_rdata};

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is not reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty && ctl_reg_rdata[ACTIVE_BIT] && !flush) begin
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // A byte still blocked by the host has not been launched, so a flush drops it.
                    if (!cfg_we) begin
                        state_q <= S_HOLD;
                    end else if (flush) begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    state_q <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    if (tx_clear) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Host writes win the port but can never reach the data or tnsm fields.
    always_comb begin
        ctl_reg_we    = 1'b0;
        ctl_reg_wdata = '0;
        ctl_reg_wmask = '0;
        if (cfg_we) begin
            ctl_reg_we    = 1'b1;
            ctl_reg_wdata = cfg_wdata;
            ctl_reg_wmask = cfg_wmask & ~OWNED_MASK;
        end else if (state_q == S_LAUNCH) begin
            ctl_reg_we    = 1'b1;
            ctl_reg_wdata = (19'(mem_q[rd_ptr_q]) << DATA_LSB) | TNSM_MASK;
            ctl_reg_wmask = OWNED_MASK;
        end
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: per-cycle vector table plus multi-cycle sequences
// driven against a small UART readback model.
module tb_uart_tx_sequencer;
    logic        clk;
    logic        arst_n;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        flush;
    logic        cfg_we;
    logic [18:0] cfg_wdata;
    logic [18:0] cfg_wmask;
    logic        ctl_reg_we;
    logic [18:0] ctl_reg_wdata;
    logic [18:0] ctl_reg_wmask;
    logic [18:0] ctl_reg_rdata;
    logic [11:0] st_reg_rdata;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        tx_done;

    uart_tx_sequencer dut (
        .clk(clk), .arst_n(arst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .flush(flush), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
        .cfg_wmask(cfg_wmask), .ctl_reg_we(ctl_reg_we), .ctl_reg_wdata(ctl_reg_wdata),
        .ctl_reg_wmask(ctl_reg_wmask), .ctl_reg_rdata(ctl_reg_rdata),
        .st_reg_rdata(st_reg_rdata), .count(count), .empty(empty), .full(full),
        .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Readback either comes straight from the vector table or from the UART model.
    logic act, t_tn, t_bz, uart_en;
    logic m_tn, m_bz;
    int   m_cnt, uart_delay;
    logic tn_sel, bz_sel;
    assign tn_sel        = uart_en ? m_tn : t_tn;
    assign bz_sel        = uart_en ? m_bz : t_bz;
    assign ctl_reg_rdata = {8'h00, tn_sel, 9'h000, act};
    assign st_reg_rdata  = {bz_sel, 11'h000};

    logic seq_launch;
    assign seq_launch = arst_n && ctl_reg_we && !cfg_we && ctl_reg_wdata[10];

    always @(posedge clk) begin
        if (!uart_en) begin
            m_tn <= 1'b0; m_bz <= 1'b0; m_cnt <= 0;
        end else if (seq_launch) begin
            m_tn <= 1'b1; m_bz <= 1'b1; m_cnt <= uart_delay;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_tn <= 1'b0; m_bz <= 1'b0;
            end
        end
    end

    int          cyc = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    int          launch_cyc = 0;
    logic [7:0]  launch_q[$];
    logic [18:0] lw_q[$];
    logic [18:0] lm_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (seq_launch) begin
            launch_q.push_back(ctl_reg_wdata[18:11]);
            lw_q.push_back(ctl_reg_wdata);
            lm_q.push_back(ctl_reg_wmask);
            launch_cyc <= cyc;
        end
        if (arst_n && tx_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_data  = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = wr_ready;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
        $display("push %02h", b);
    endtask

    task automatic wait_done(input int target, input int maxc);
        for (int i = 0; i < maxc && done_n < target; i++) begin
            @(posedge clk); #1;
        end
        chk("done_count", done_n, target);
    endtask

    typedef struct {
        logic        wv;  logic [7:0]  wd;
        logic        cwe; logic [18:0] cwd; logic [18:0] cwm;
        logic        ac;  logic        tn;  logic        bz;
        logic [4:0]  e_cnt; logic e_we; logic [18:0] e_wd; logic [18:0] e_wm; logic e_done;
    } vec_t;

    vec_t tbl[19];
    int   base_l, base_d;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[1]  = '{1, 8'hA5, 0, 19'h0,     19'h0,     1, 0, 0, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[2]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd1, 0, 19'h0,     19'h0,     0};
        tbl[3]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd1, 1, 19'h52C00, 19'h7FC00, 0};
        tbl[4]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 1, 1, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[5]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 1, 0, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[6]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 1, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[7]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd0, 0, 19'h0,     19'h0,     1};
        tbl[8]  = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[9]  = '{0, 8'h00, 1, 19'h7FFFF, 19'h7FFFF, 1, 0, 0, 5'd0, 1, 19'h7FFFF, 19'h003FF, 0};
        tbl[10] = '{0, 8'h00, 1, 19'h12345, 19'h40001, 1, 0, 0, 5'd0, 1, 19'h12345, 19'h00001, 0};
        tbl[11] = '{1, 8'h3C, 0, 19'h0,     19'h0,     1, 0, 0, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[12] = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd1, 0, 19'h0,     19'h0,     0};
        tbl[13] = '{0, 8'h00, 1, 19'h00001, 19'h7FFFF, 1, 0, 0, 5'd1, 1, 19'h00001, 19'h003FF, 0};
        tbl[14] = '{0, 8'h00, 1, 19'h00001, 19'h7FFFF, 1, 0, 0, 5'd1, 1, 19'h00001, 19'h003FF, 0};
        tbl[15] = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd1, 1, 19'h1E400, 19'h7FC00, 0};
        tbl[16] = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 1, 1, 5'd0, 0, 19'h0,     19'h0,     0};
        tbl[17] = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd0, 0, 19'h0,     19'h0,     1};
        tbl[18] = '{0, 8'h00, 0, 19'h0,     19'h0,     1, 0, 0, 5'd0, 0, 19'h0,     19'h0,     0};

        arst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0;
        cfg_we = 1'b0; cfg_wdata = '0; cfg_wmask = '0;
        act = 1'b0; t_tn = 1'b0; t_bz = 1'b0; uart_en = 1'b0; uart_delay = 1;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_we", 32'(ctl_reg_we), 0);
        chk("rst_wdata", 32'(ctl_reg_wdata), 0);
        chk("rst_wmask", 32'(ctl_reg_wmask), 0);
        chk("rst_tx_done", 32'(tx_done), 0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            wr_valid = tbl[i].wv;  wr_data = tbl[i].wd;
            cfg_we = tbl[i].cwe;   cfg_wdata = tbl[i].cwd; cfg_wmask = tbl[i].cwm;
            act = tbl[i].ac;       t_tn = tbl[i].tn;       t_bz = tbl[i].bz;
            @(negedge clk);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
            chk($sformatf("v%0d_we", i), 32'(ctl_reg_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d_wdata", i), 32'(ctl_reg_wdata), 32'(tbl[i].e_wd));
            chk($sformatf("v%0d_wmask", i), 32'(ctl_reg_wmask), 32'(tbl[i].e_wm));
            chk($sformatf("v%0d_tx_done", i), 32'(tx_done), 32'(tbl[i].e_done));
            $display("vec %0d: count=%0d we=%0b wdata=%05h wmask=%05h tx_done=%0b",
                     i, count, ctl_reg_we, ctl_reg_wdata, ctl_reg_wmask, tx_done);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0; cfg_we = 1'b0; cfg_wdata = '0; cfg_wmask = '0;
        t_tn = 1'b0; t_bz = 1'b0; uart_en = 1'b1;

        // Single byte, UART clears tnsm 20 cycles after the launch.
        uart_delay = 20; act = 1'b1;
        base_l = launch_q.size(); base_d = done_n;
        push(8'hA5);
        wait_done(base_d + 1, 100);
        repeat (5) @(posedge clk); #1;
        chk("a5_launches", launch_q.size() - base_l, 1);
        chk("a5_wdata", 32'(lw_q[base_l]), 32'h52C00);
        chk("a5_wmask", 32'(lm_q[base_l]), 32'h7FC00);
        chk("a5_done_once", done_n - base_d, 1);
        chk("a5_done_after_clear", 32'(done_cyc - launch_cyc >= 20), 1);
        $display("a5: launch@%0d done@%0d", launch_cyc, done_cyc);

        // Fill to DEPTH with launches held off, then release.
        act = 1'b0; uart_delay = 2;
        base_l = launch_q.size(); base_d = done_n;
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        chk("full_flag", 32'(full), 1);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("full_count", 32'(count), 16);
        wr_valid = 1'b1; wr_data = 8'h50;
        repeat (3) @(posedge clk); #1;
        chk("full_17th_waits", 32'(count), 16);
        act = 1'b1;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = wr_ready;
                @(posedge clk); #1;
            end
            wr_valid = 1'b0;
            chk("full_17th_accept", 32'(ok), 1);
        end
        wait_done(base_d + 17, 400);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] got;
            got = (launch_q.size() > base_l + i) ? launch_q[base_l + i] : 8'hXX;
            chk($sformatf("order_%0d", i), 32'(got), 32'(8'h40 + i));
            $display("drain %0d: byte %02h", i, got);
        end

        // Flush while one byte is waiting for tnsm to clear.
        uart_delay = 20;
        base_l = launch_q.size(); base_d = done_n;
        push(8'h01);
        for (int i = 0; i < 20 && launch_q.size() == base_l; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) push(8'(8'h02 + i));
        chk("flush_pre_count", 32'(count), 5);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        wait_done(base_d + 1, 100);
        repeat (10) @(posedge clk); #1;
        chk("flush_launches", launch_q.size() - base_l, 1);
        chk("flush_done_once", done_n - base_d, 1);

        // Bytes queued while inactive stay put until active returns.
        act = 1'b0; uart_delay = 3;
        base_l = launch_q.size(); base_d = done_n;
        push(8'h11); push(8'h22); push(8'h33);
        repeat (10) @(posedge clk); #1;
        chk("inactive_no_launch", launch_q.size() - base_l, 0);
        chk("inactive_count", 32'(count), 3);
        act = 1'b1;
        wait_done(base_d + 3, 100);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] got;
            got = (launch_q.size() > base_l + i) ? launch_q[base_l + i] : 8'hXX;
            chk($sformatf("inactive_order_%0d", i), 32'(got), 32'(8'h11 * (i + 1)));
        end

        // Asynchronous reset while a launch write is on the port.
        uart_delay = 20;
        wr_valid = 1'b1; wr_data = 8'h77;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = ctl_reg_we;
            end
            chk("rst_mid_launch_reached", 32'(seen), 1);
        end
        #2 arst_n = 1'b0;
        #1;
        chk("arst_we", 32'(ctl_reg_we), 0);
        chk("arst_wdata", 32'(ctl_reg_wdata), 0);
        chk("arst_wmask", 32'(ctl_reg_wmask), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_wr_ready", 32'(wr_ready), 1);
        chk("arst_tx_done", 32'(tx_done), 0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Transmit-side front end placed directly upstream of the UART control-register port. It buffers host bytes in a FIFO and launches each one into the UART by writing data plus the `tnsm` bit through the masked control-register write port. It then waits for the transmitter to clear `tnsm` and go idle before launching the next byte. Host configuration writes share the same port through a fixed-priority merge.

## Interface

- `DEPTH`, 16: FIFO depth in bytes; power of two, minimum 2.
- `ACTIVE_BIT`, 0: index of the `active` bit in the control register.
- `TNSM_BIT`, 10: index of the `tnsm` bit in the control register.
- `DATA_LSB`, 11: LSB of the 8-bit transmit data field in the control register.
- `TBUSY_BIT`, 11: index of transmitter busy in the status register.

- `clk` in 1: system clock.
- `arst_n` in 1: asynchronous active-low reset.
- `wr_valid` in 1: host byte valid.
- `wr_data` in 8: host byte.
- `wr_ready` out 1: FIFO can accept a byte; equals `!full`.
- `flush` in 1: discard all queued bytes.
- `cfg_we` in 1: host config write request.
- `cfg_wdata` in 19: host config write data.
- `cfg_wmask` in 19: host config write mask.
- `ctl_reg_we` out 1: control-register write enable.
- `ctl_reg_wdata` out 19: control-register write data.
- `ctl_reg_wmask` out 19: control-register write mask.
- `ctl_reg_rdata` in 19: control-register readback.
- `st_reg_rdata` in 12: status-register readback, observed only; this block never asserts read-enable.
- `count` out $clog2(DEPTH)+1: bytes queued.
- `empty` out 1: `count==0`.
- `full` out 1: `count==DEPTH`.
- `tx_done` out 1: one-cycle pulse when a launched byte has completed.

## Operation

- FIFO:
  - Push when `wr_valid && wr_ready`.
  - Pop at the clock edge leaving LAUNCH.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves `count` unchanged.
- `flush`:
  - Clears the pointers and `count` at the next edge.
  - Overrides a same-cycle push; that byte is dropped.
  - Does not abort a byte that has already been launched.
- FSM states:
  - IDLE → LAUNCH when `!empty && ctl_reg_rdata[ACTIVE_BIT] && !flush`.
  - LAUNCH → HOLD when `!cfg_we`. If `cfg_we` is asserted, the FSM stays in LAUNCH and retries.
  - HOLD → WAIT_CLR unconditionally, after one cycle. This cycle covers register write latency; readback is ignored.
  - WAIT_CLR → IDLE when `ctl_reg_rdata[TNSM_BIT]==0 && st_reg_rdata[TBUSY_BIT]==0`. `tx_done` pulses in the cycle of this transition.
- Port merge (combinational):
  - If `cfg_we`: the outputs are `we=1`, `wdata=cfg_wdata`, `wmask=cfg_wmask` with bits `TNSM_BIT` and `DATA_LSB+7..DATA_LSB` forced to 0. The host can never touch the data or `tnsm` fields.
  - Else in LAUNCH: `we=1`, `wdata` = FIFO head placed at `DATA_LSB` with bit `TNSM_BIT`=1 (other bits 0), `wmask` = ones only on the data field and `TNSM_BIT`.
  - Otherwise: `we=0`; `wdata` and `wmask` are 0.
- Clearing `active` while the FSM is in WAIT_CLR has no special handling; the FSM waits for the exit condition as normal. No new launch occurs while `active`=0.
- Reset values:
  - FSM in IDLE; FIFO empty.
  - `count=0`, `empty=1`, `full=0`, `wr_ready=1`.
  - `ctl_reg_we=0`, `ctl_reg_wdata=0`, `ctl_reg_wmask=0`, `tx_done=0`.
- Reset mid-operation aborts everything immediately; queued bytes are lost.

## Timing

- Byte accepted at edge k with the FIFO empty, `active`=1, and no `cfg_we`:
  - `empty` falls after edge k.
  - The FSM enters LAUNCH at edge k+1.
  - `ctl_reg_we` is high for exactly the cycle between edges k+1 and k+2.
  - The pop occurs at edge k+2.
- Minimum spacing between two launches is 4 cycles: LAUNCH, HOLD, at least one WAIT_CLR cycle, IDLE.
- `wr_ready` deasserts in the cycle after the edge that makes `count==DEPTH`. A pop in the cycle while full does not reopen `wr_ready` until the following cycle.
- Each `cfg_we` cycle during LAUNCH delays the launch by one cycle. The byte is neither lost nor duplicated.
- Flow control on `tnsm` and busy comes only from the readback inputs. No timeout exists.

## Test plan

- Reset with `arst_n` low mid-LAUNCH:
  - Required: all outputs return to their reset values asynchronously, with `wr_ready=1` and `ctl_reg_we=0`.
- Push 0xA5 with `active`=1, then model the UART clearing `tnsm` 20 cycles later:
  - Required: one write with `wdata[18:11]=0xA5`, `wdata[10]=1`, `wmask=0x7FC00`.
  - Required: `tx_done` pulses exactly once, after the clear.
- Push 17 bytes with DEPTH=16 while the UART is held busy:
  - Required: `full=1` and `wr_ready=0` after 16 pushes; the 17th byte waits.
  - Required: on release, bytes emerge in order with no loss.
- Assert `cfg_we` with `cfg_wmask=0x7FFFF` during LAUNCH for 2 cycles:
  - Required: the outputs show the config write with `wmask=0x003FF`.
  - Required: the byte is launched on the third cycle, exactly once.
- `flush` with 5 queued bytes while one byte is in WAIT_CLR:
  - Required: `count` goes to 0 at the next edge.
  - Required: the in-flight byte still produces `tx_done`, and no further launches follow.
- `active`=0 with 3 bytes queued:
  - Required: no `ctl_reg_we` from the sequencer.
  - Required: after `active`=1, 3 launches occur in FIFO order.
